// File: rtl/slv_guard_isolate.sv
`default_nettype none
// ============================================================================
// Module      : slv_guard_isolate
// Description : AXI subordinate guard. Forwards traffic with outstanding-
//               transaction limits, times out stuck writes/reads, resets the
//               subordinate through a handshake and answers with SLVERR
//               while isolated.
// Revision    : 1.0 - initial release
// ============================================================================

package slv_guard_isolate_pkg;
    typedef struct packed {
        logic [3:0]  aw_id;
        logic [31:0] aw_addr;
        logic [7:0]  aw_len;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [3:0]  ar_id;
        logic [31:0] ar_addr;
        logic [7:0]  ar_len;
        logic        ar_valid;
        logic        r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
    } axi_rsp_t;
endpackage

module slv_guard_isolate #(
    parameter int unsigned MaxTxns      = 4,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned PrescalerDiv = 1,
    parameter logic [1:0]  ErrResp      = 2'b10,
    parameter type         req_t        = slv_guard_isolate_pkg::axi_req_t,
    parameter type         rsp_t        = slv_guard_isolate_pkg::axi_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                guard_ena_i,
    input  logic [CntWidth-1:0] budget_wr_i,
    input  logic [CntWidth-1:0] budget_rd_i,
    input  logic                clr_i,
    input  req_t                req_i,
    output rsp_t                rsp_o,
    output req_t                req_o,
    input  rsp_t                rsp_i,
    output logic                irq_o,
    output logic [1:0]          status_o,
    output logic                rst_req_o,
    input  logic                rst_stat_i
);

    localparam int CW = $clog2(MaxTxns + 1);
    localparam logic [CW-1:0] MAX_OUT = CW'(MaxTxns);
    localparam int PW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PrescalerDiv - 1);

    typedef enum logic [1:0] {RUN, RST_REQ, RST_DONE, ISOLATED} top_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    top_state_t state, state_nxt;
    wr_state_t  wst, wst_nxt;
    rd_state_t  rst_s, rst_s_nxt;

    logic [CW-1:0]       wr_out, rd_out, w_pend;
    logic [CntWidth-1:0] wr_tmr, rd_tmr;
    logic [PW-1:0]       presc;
    logic                clr_pend;
    logic [$bits(req_i.aw_id)-1:0]  err_b_id;
    logic [$bits(req_i.ar_id)-1:0]  err_r_id;
    logic [$bits(req_i.ar_len)-1:0] beats_left;

    logic run, tick, wr_full, rd_full, w_drain;
    logic aw_hs, b_hs, wl_hs, ar_hs, rl_hs, drop_last;
    logic err_aw_hs, err_w_last, err_b_hs, err_ar_hs, err_r_hs, err_r_last;
    logic wr_to, rd_to, leave_iso;

    assign run      = (state == RUN);
    assign tick     = (presc == PRESC_LAST);
    assign wr_full  = (wr_out == MAX_OUT);
    assign rd_full  = (rd_out == MAX_OUT);
    assign w_drain  = !run && (w_pend != '0);

    // Handshakes on the forwarded path only count while in service.
    assign aw_hs = run && req_i.aw_valid && rsp_i.aw_ready && !wr_full;
    assign b_hs  = run && rsp_i.b_valid && req_i.b_ready;
    assign wl_hs = run && req_i.w_valid && rsp_i.w_ready && req_i.w_last;
    assign ar_hs = run && req_i.ar_valid && rsp_i.ar_ready && !rd_full;
    assign rl_hs = run && rsp_i.r_valid && req_i.r_ready && rsp_i.r_last;

    // Orphan W beats of writes forwarded before the timeout are swallowed.
    assign drop_last  = w_drain && req_i.w_valid && req_i.w_last;
    assign err_aw_hs  = !run && (wst == W_IDLE) && (w_pend == '0) && req_i.aw_valid;
    assign err_w_last = !run && (wst == W_DATA) && !w_drain && req_i.w_valid && req_i.w_last;
    assign err_b_hs   = !run && (wst == W_RESP) && req_i.b_ready;
    assign err_ar_hs  = !run && (rst_s == R_IDLE) && req_i.ar_valid;
    assign err_r_hs   = !run && (rst_s == R_DATA) && req_i.r_ready;
    assign err_r_last = (beats_left == '0);

    assign wr_to = guard_ena_i && (budget_wr_i != '0) && run && (wr_tmr >= budget_wr_i);
    assign rd_to = guard_ena_i && (budget_rd_i != '0) && run && (rd_tmr >= budget_rd_i);

    assign leave_iso = (state == ISOLATED) && clr_pend && (wst == W_IDLE)
                       && (rst_s == R_IDLE) && (w_pend == '0);

    assign irq_o = |status_o;

    // State registers for the top FSM and both error-responder FSMs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            wst   <= W_IDLE;
            rst_s <= R_IDLE;
        end else begin
            state <= state_nxt;
            wst   <= wst_nxt;
            rst_s <= rst_s_nxt;
        end
    end

    // Next-state logic for the top FSM and the error responders.
    always_comb begin
        state_nxt = state;
        wst_nxt   = wst;
        rst_s_nxt = rst_s;
        case (state)
            RUN:      if (wr_to || rd_to) state_nxt = RST_REQ;
            RST_REQ:  if (rst_stat_i)     state_nxt = RST_DONE;
            RST_DONE: if (!rst_stat_i)    state_nxt = ISOLATED;
            ISOLATED: if (leave_iso)      state_nxt = RUN;
            default:                      state_nxt = RUN;
        endcase
        case (wst)
            W_IDLE:  if (err_aw_hs)  wst_nxt = W_DATA;
            W_DATA:  if (err_w_last) wst_nxt = W_RESP;
            W_RESP:  if (err_b_hs)   wst_nxt = W_IDLE;
            default:                 wst_nxt = W_IDLE;
        endcase
        case (rst_s)
            R_IDLE:  if (err_ar_hs)               rst_s_nxt = R_DATA;
            R_DATA:  if (err_r_hs && err_r_last)  rst_s_nxt = R_IDLE;
            default:                              rst_s_nxt = R_IDLE;
        endcase
    end

    // Output muxing: gated pass-through in service, error responder otherwise.
    always_comb begin
        req_o     = '0;
        rsp_o     = '0;
        rst_req_o = (state == RST_REQ);
        if (run) begin
            req_o          = req_i;
            rsp_o          = rsp_i;
            req_o.aw_valid = req_i.aw_valid && !wr_full;
            rsp_o.aw_ready = rsp_i.aw_ready && !wr_full;
            req_o.ar_valid = req_i.ar_valid && !rd_full;
            rsp_o.ar_ready = rsp_i.ar_ready && !rd_full;
        end else begin
            rsp_o.aw_ready = (wst == W_IDLE) && (w_pend == '0);
            rsp_o.w_ready  = w_drain || (wst == W_DATA);
            rsp_o.b_valid  = (wst == W_RESP);
            rsp_o.b_id     = err_b_id;
            rsp_o.b_resp   = ErrResp;
            rsp_o.ar_ready = (rst_s == R_IDLE);
            rsp_o.r_valid  = (rst_s == R_DATA);
            rsp_o.r_id     = err_r_id;
            rsp_o.r_resp   = ErrResp;
            rsp_o.r_last   = (rst_s == R_DATA) && err_r_last;
        end
    end

    // Latch IDs and remaining beat count for the generated error responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_b_id   <= '0;
            err_r_id   <= '0;
            beats_left <= '0;
        end else begin
            if (err_aw_hs) err_b_id <= req_i.aw_id;
            if (err_ar_hs) begin
                err_r_id   <= req_i.ar_id;
                beats_left <= req_i.ar_len;
            end else if (err_r_hs && !err_r_last) begin
                beats_left <= beats_left - 1'b1;
            end
        end
    end

    // Free-running prescaler producing one tick every PrescalerDiv cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Outstanding-transaction and pending-W-data bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_out <= '0;
            rd_out <= '0;
            w_pend <= '0;
        end else if (leave_iso) begin
            wr_out <= '0;
            rd_out <= '0;
            w_pend <= '0;
        end else begin
            if (aw_hs && !b_hs)      wr_out <= wr_out + 1'b1;
            else if (b_hs && !aw_hs) wr_out <= wr_out - 1'b1;
            if (ar_hs && !rl_hs)      rd_out <= rd_out + 1'b1;
            else if (rl_hs && !ar_hs) rd_out <= rd_out - 1'b1;
            if (run) begin
                if (aw_hs && !wl_hs)                        w_pend <= w_pend + 1'b1;
                else if (wl_hs && !aw_hs && w_pend != '0)   w_pend <= w_pend - 1'b1;
            end else if (drop_last) begin
                w_pend <= w_pend - 1'b1;
            end
        end
    end

    // Saturating timeout timers, idle while nothing is outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_tmr <= '0;
            rd_tmr <= '0;
        end else if (leave_iso) begin
            wr_tmr <= '0;
            rd_tmr <= '0;
        end else begin
            if (wr_out == '0 || b_hs)      wr_tmr <= '0;
            else if (tick && wr_tmr != '1) wr_tmr <= wr_tmr + 1'b1;
            if (rd_out == '0 || rl_hs)     rd_tmr <= '0;
            else if (tick && rd_tmr != '1) rd_tmr <= rd_tmr + 1'b1;
        end
    end

    // Sticky timeout status and the pending return-to-service request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_o <= '0;
            clr_pend <= 1'b0;
        end else if (leave_iso) begin
            status_o <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (wr_to || rd_to)    status_o <= status_o | {rd_to, wr_to};
            else if (run && clr_i) status_o <= '0;
            if (!run && clr_i)     clr_pend <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slv_guard_isolate.sv
`default_nettype none
// ============================================================================
// Module      : tb_slv_guard_isolate
// Description : Self-checking bench for slv_guard_isolate with randomized
//               traffic against an outstanding-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slv_guard_isolate;
    import slv_guard_isolate_pkg::*;

    localparam int MAXT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       guard_ena = 1'b0;
    logic [7:0] budget_wr = '0, budget_rd = '0;
    logic       clr = 1'b0;
    axi_req_t   req_i, req_o;
    axi_rsp_t   rsp_i, rsp_o;
    logic       irq;
    logic [1:0] status;
    logic       rst_req;
    logic       rst_stat = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    slv_guard_isolate #(
        .MaxTxns(MAXT), .CntWidth(8), .PrescalerDiv(1), .ErrResp(2'b10),
        .req_t(axi_req_t), .rsp_t(axi_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst), .guard_ena_i(guard_ena),
        .budget_wr_i(budget_wr), .budget_rd_i(budget_rd), .clr_i(clr),
        .req_i(req_i), .rsp_o(rsp_o), .req_o(req_o), .rsp_i(rsp_i),
        .irq_o(irq), .status_o(status), .rst_req_o(rst_req), .rst_stat_i(rst_stat)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic axi_req_t rand_req();
        logic [$bits(axi_req_t)-1:0] v;
        for (int i = 0; i < $bits(axi_req_t); i++) v[i] = 1'($urandom_range(1, 0));
        return axi_req_t'(v);
    endfunction

    function automatic axi_rsp_t rand_rsp();
        logic [$bits(axi_rsp_t)-1:0] v;
        for (int i = 0; i < $bits(axi_rsp_t); i++) v[i] = 1'($urandom_range(1, 0));
        return axi_rsp_t'(v);
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_i = '0; rsp_i = '0; clr = 1'b0; rst_stat = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        guard_ena = 1'b0; budget_wr = '0; budget_rd = '0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic wait_rst_req(output int edges);
        edges = 0;
        while (!rst_req && edges < 40) begin
            cyc();
            edges++;
        end
    endtask

    // Timeout on one forwarded write, reset handshake, lands in ISOLATED.
    task automatic go_isolated();
        int e;
        guard_ena = 1'b1; budget_wr = 8'd10;
        req_i.aw_valid = 1'b1; rsp_i.aw_ready = 1'b1;
        cyc();
        clear_inputs();
        req_i.w_valid = 1'b1; req_i.w_last = 1'b1; rsp_i.w_ready = 1'b1;
        cyc();
        clear_inputs();
        wait_rst_req(e);
        n_cmp++;
        if (rst_req !== 1'b1) begin
            n_err++; $display("FAIL iso_rst_req: got %b want 1", rst_req);
        end
        rst_stat = 1'b1;
        cyc();
        #1;
        n_cmp++;
        if (rst_req !== 1'b0) begin
            n_err++; $display("FAIL iso_rst_done: got %b want 0", rst_req);
        end
        rst_stat = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_i = rand_req(); rsp_i = rand_rsp();
        #1;
        n_cmp++;
        if ({status, irq, rst_req} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {status, irq, rst_req});
        end
        n_cmp++;
        if (req_o !== req_i) begin
            n_err++; $display("FAIL reset_req_pass: got %h want %h", req_o, req_i);
        end
        n_cmp++;
        if (rsp_o !== rsp_i) begin
            n_err++; $display("FAIL reset_rsp_pass: got %h want %h", rsp_o, rsp_i);
        end
        cyc();
        rst = 1'b0;
        clear_inputs();
        cyc();
    endtask

    task automatic test_random_traffic();
        int wr = 0, rd = 0;
        axi_req_t ereq;
        axi_rsp_t ersp;
        logic aw, b, ar, rl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_i = rand_req(); rsp_i = rand_rsp();
            rsp_i.b_valid = (wr > 0) && ($urandom_range(3, 0) == 0);
            rsp_i.r_valid = (rd > 0) && ($urandom_range(3, 0) == 0);
            #1;
            ereq = req_i; ersp = rsp_i;
            ereq.aw_valid = req_i.aw_valid && (wr < MAXT);
            ersp.aw_ready = rsp_i.aw_ready && (wr < MAXT);
            ereq.ar_valid = req_i.ar_valid && (rd < MAXT);
            ersp.ar_ready = rsp_i.ar_ready && (rd < MAXT);
            n_cmp++;
            if (req_o !== ereq) begin
                n_err++; $display("FAIL rand_req c=%0d: got %h want %h", c, req_o, ereq);
            end
            n_cmp++;
            if (rsp_o !== ersp) begin
                n_err++; $display("FAIL rand_rsp c=%0d: got %h want %h", c, rsp_o, ersp);
            end
            aw = req_i.aw_valid && rsp_i.aw_ready && (wr < MAXT);
            b  = rsp_i.b_valid && req_i.b_ready;
            ar = req_i.ar_valid && rsp_i.ar_ready && (rd < MAXT);
            rl = rsp_i.r_valid && req_i.r_ready && rsp_i.r_last;
            wr = wr + int'(aw) - int'(b);
            rd = rd + int'(ar) - int'(rl);
            cyc();
        end
    endtask

    task automatic test_timeout_write();
        int e;
        do_reset();
        guard_ena = 1'b1; budget_wr = 8'd10;
        req_i.aw_valid = 1'b1; req_i.aw_id = 4'd2; rsp_i.aw_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_o.aw_valid !== 1'b1) begin
            n_err++; $display("FAIL tow_fwd: got %b want 1", req_o.aw_valid);
        end
        cyc();
        clear_inputs();
        wait_rst_req(e);
        n_cmp++;
        if (e !== 11) begin
            n_err++; $display("FAIL tow_latency: got %0d want 11", e);
        end
        n_cmp++;
        if ({status, irq} !== 3'b011) begin
            n_err++; $display("FAIL tow_status: got %b want 011", {status, irq});
        end
        req_i = rand_req();
        #1;
        n_cmp++;
        if (req_o !== '0) begin
            n_err++; $display("FAIL tow_isolated_req: got %h want 0", req_o);
        end
    endtask

    task automatic test_timeout_read_random();
        int e, bud;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            bud = $urandom_range(20, 2);
            guard_ena = 1'b1; budget_rd = 8'(bud);
            req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
            cyc();
            clear_inputs();
            wait_rst_req(e);
            n_cmp++;
            if (e !== bud + 1 || status !== 2'b10) begin
                n_err++; $display("FAIL tor_budget%0d: got lat %0d st %b want lat %0d st 10", bud, e, status, bud + 1);
            end
        end
    endtask

    task automatic test_simul_timeout();
        int e;
        do_reset();
        guard_ena = 1'b1; budget_wr = 8'd10; budget_rd = 8'd10;
        req_i.aw_valid = 1'b1; rsp_i.aw_ready = 1'b1;
        req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
        cyc();
        clear_inputs();
        wait_rst_req(e);
        n_cmp++;
        if (status !== 2'b11 || e !== 11) begin
            n_err++; $display("FAIL simul_to: got st %b lat %0d want st 11 lat 11", status, e);
        end
    endtask

    task automatic test_guard_disable();
        logic seen = 1'b0;
        do_reset();
        guard_ena = 1'b0; budget_wr = 8'd5;
        req_i.aw_valid = 1'b1; rsp_i.aw_ready = 1'b1;
        cyc();
        clear_inputs();
        for (int c = 0; c < 30; c++) begin
            cyc();
            seen = seen | rst_req;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL guard_off: got %b want 0", seen);
        end
        guard_ena = 1'b1;
        cyc();
        n_cmp++;
        if ({rst_req, status} !== 3'b101) begin
            n_err++; $display("FAIL guard_on: got %b want 101", {rst_req, status});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({rsp_o.ar_ready, req_o.ar_valid} !== 2'b00) begin
                n_err++; $display("FAIL bp_gated%0d: got %b want 00", i, {rsp_o.ar_ready, req_o.ar_valid});
            end
            cyc();
        end
        rsp_i.r_valid = 1'b1; rsp_i.r_last = 1'b1; req_i.r_ready = 1'b1;
        #1;
        n_cmp++;
        if (rsp_o.ar_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_same_cycle: got %b want 0", rsp_o.ar_ready);
        end
        cyc();
        rsp_i.r_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_o.ar_ready, req_o.ar_valid} !== 2'b11) begin
            n_err++; $display("FAIL bp_release: got %b want 11", {rsp_o.ar_ready, req_o.ar_valid});
        end
        cyc();
    endtask

    task automatic test_error_read();
        int beats = 0;
        do_reset();
        go_isolated();
        req_i.ar_valid = 1'b1; req_i.ar_id = 4'd1; req_i.ar_len = 8'd3;
        #1;
        n_cmp++;
        if (rsp_o.ar_ready !== 1'b1) begin
            n_err++; $display("FAIL er_ar_ready: got %b want 1", rsp_o.ar_ready);
        end
        cyc();
        req_i.ar_valid = 1'b0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            req_i.r_ready = 1'($urandom_range(1, 0));
            #1;
            if (rsp_o.r_valid) begin
                n_cmp++;
                if ({rsp_o.r_id, rsp_o.r_resp, rsp_o.r_data, rsp_o.r_last} !== {4'd1, 2'b10, 32'd0, beats == 3}) begin
                    n_err++; $display("FAIL er_beat%0d: got id %h resp %b data %h last %b", beats, rsp_o.r_id, rsp_o.r_resp, rsp_o.r_data, rsp_o.r_last);
                end
                if (req_i.r_ready) beats++;
            end
            cyc();
        end
        req_i.r_ready = 1'b1;
        repeat (3) begin
            #1;
            if (rsp_o.r_valid) beats++;
            cyc();
        end
        n_cmp++;
        if (beats !== 4) begin
            n_err++; $display("FAIL er_count: got %0d want 4", beats);
        end
        req_i.ar_valid = 1'b1; req_i.ar_len = 8'd7;
        cyc();
        req_i.ar_valid = 1'b0;
        repeat (2) cyc();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_o.r_valid !== 1'b0) begin
            n_err++; $display("FAIL midburst_async: got %b want 0", rsp_o.r_valid);
        end
        cyc();
        rst = 1'b0;
        clear_inputs();
        req_i = rand_req(); rsp_i = rand_rsp();
        rsp_i.aw_ready = 1'b0; rsp_i.ar_ready = 1'b0;
        #1;
        n_cmp++;
        if (rsp_o !== rsp_i || rst_req !== 1'b0 || status !== 2'b00) begin
            n_err++; $display("FAIL midburst_release: got %h want %h", rsp_o, rsp_i);
        end
        cyc();
    endtask

    task automatic test_orphan_w();
        int e;
        logic got_b = 1'b0;
        do_reset();
        guard_ena = 1'b1; budget_wr = 8'd10;
        req_i.aw_valid = 1'b1; req_i.aw_id = 4'd3; req_i.aw_len = 8'd3; rsp_i.aw_ready = 1'b1;
        cyc();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req_i.w_valid = 1'b1; rsp_i.w_ready = 1'b1;
            #1;
            n_cmp++;
            if (req_o.w_valid !== 1'b1) begin
                n_err++; $display("FAIL ow_fwd%0d: got %b want 1", i, req_o.w_valid);
            end
            cyc();
        end
        clear_inputs();
        wait_rst_req(e);
        #1;
        n_cmp++;
        if ({rst_req, rsp_o.aw_ready} !== 2'b10) begin
            n_err++; $display("FAIL ow_aw_blocked: got %b want 10", {rst_req, rsp_o.aw_ready});
        end
        for (int i = 0; i < 2; i++) begin
            req_i.w_valid = 1'b1; req_i.w_last = (i == 1);
            #1;
            n_cmp++;
            if ({rsp_o.w_ready, req_o.w_valid} !== 2'b10) begin
                n_err++; $display("FAIL ow_drop%0d: got %b want 10", i, {rsp_o.w_ready, req_o.w_valid});
            end
            cyc();
        end
        clear_inputs();
        #1;
        n_cmp++;
        if ({rsp_o.aw_ready, rsp_o.b_valid, rsp_o.w_ready} !== 3'b100) begin
            n_err++; $display("FAIL ow_drained: got %b want 100", {rsp_o.aw_ready, rsp_o.b_valid, rsp_o.w_ready});
        end
        rst_stat = 1'b1; cyc();
        rst_stat = 1'b0; cyc();
        req_i.aw_valid = 1'b1; req_i.aw_id = 4'd9;
        cyc();
        req_i.aw_valid = 1'b0;
        req_i.w_valid = 1'b1; req_i.w_last = 1'b1;
        #1;
        n_cmp++;
        if (rsp_o.w_ready !== 1'b1) begin
            n_err++; $display("FAIL ow_err_w: got %b want 1", rsp_o.w_ready);
        end
        cyc();
        req_i.w_valid = 1'b0; req_i.b_ready = 1'b1;
        for (int c = 0; c < 10 && !got_b; c++) begin
            #1;
            if (rsp_o.b_valid) begin
                got_b = 1'b1;
                n_cmp++;
                if ({rsp_o.b_id, rsp_o.b_resp} !== {4'd9, 2'b10}) begin
                    n_err++; $display("FAIL ow_b: got id %h resp %b want id 9 resp 10", rsp_o.b_id, rsp_o.b_resp);
                end
            end
            cyc();
        end
        n_cmp++;
        if (got_b !== 1'b1) begin
            n_err++; $display("FAIL ow_b_seen: got %b want 1", got_b);
        end
        clear_inputs();
    endtask

    task automatic test_recovery();
        int beats = 0;
        logic early = 1'b0;
        do_reset();
        go_isolated();
        req_i.ar_addr = 32'hCAFE_0000;
        req_i.ar_valid = 1'b1; req_i.ar_id = 4'd4; req_i.ar_len = 8'd5;
        cyc();
        req_i.ar_valid = 1'b0; req_i.r_ready = 1'b1;
        cyc();
        beats = 1;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        beats = 2;
        while (beats < 6) begin
            #1;
            early = early | (req_o.ar_addr !== 32'h0);
            cyc();
            beats++;
        end
        #1;
        n_cmp++;
        if (early !== 1'b0 || req_o.ar_addr !== 32'h0) begin
            n_err++; $display("FAIL rec_early: got early %b addr %h want 0", early, req_o.ar_addr);
        end
        cyc();
        #1;
        n_cmp++;
        if (req_o.ar_addr !== 32'hCAFE_0000 || {status, irq, rst_req} !== 4'b0) begin
            n_err++; $display("FAIL rec_run: got addr %h flags %b want cafe0000 0000", req_o.ar_addr, {status, irq, rst_req});
        end
        for (int i = 0; i < 4; i++) begin
            req_i.ar_valid = 1'b1; rsp_i.ar_ready = 1'b1;
            cyc();
        end
        #1;
        n_cmp++;
        if (rsp_o.ar_ready !== 1'b0) begin
            n_err++; $display("FAIL rec_counter: got %b want 0", rsp_o.ar_ready);
        end
        clear_inputs();
        cyc();
    endtask

    initial begin
        clear_inputs();
        cyc();
        test_reset();
        test_random_traffic();
        test_timeout_write();
        test_timeout_read_random();
        test_simul_timeout();
        test_guard_disable();
        test_backpressure();
        test_error_read();
        test_orphan_w();
        test_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
